// File: rtl/adam_apb_timer_pkg.sv
// Shared definitions for the APB timer: register map, CTRL/STATUS bit
// positions, CTRL register layout and the pause-handshake state encoding.
package adam_apb_timer_pkg;

   localparam int unsigned TIMER_ADDR_WIDTH = 32;
   localparam int unsigned TIMER_DATA_WIDTH = 32;

   // Byte offsets relative to the slot base
   localparam logic [7:0] OFF_CTRL    = 8'h00;
   localparam logic [7:0] OFF_PRESC   = 8'h04;
   localparam logic [7:0] OFF_VALUE   = 8'h08;
   localparam logic [7:0] OFF_COMPARE = 8'h0C;
   localparam logic [7:0] OFF_STATUS  = 8'h10;

   // Word index (paddr[4:2]) of each register
   localparam logic [2:0] IDX_CTRL    = OFF_CTRL[4:2];
   localparam logic [2:0] IDX_PRESC   = OFF_PRESC[4:2];
   localparam logic [2:0] IDX_VALUE   = OFF_VALUE[4:2];
   localparam logic [2:0] IDX_COMPARE = OFF_COMPARE[4:2];
   localparam logic [2:0] IDX_STATUS  = OFF_STATUS[4:2];

   localparam int unsigned CTRL_EN_BIT      = 0;
   localparam int unsigned CTRL_AR_BIT      = 1;
   localparam int unsigned CTRL_IRQ_EN_BIT  = 2;
   localparam int unsigned STATUS_MATCH_BIT = 0;

   // CTRL layout, bit 0 = en
   typedef struct packed {
      logic irq_en;
      logic auto_reload;
      logic en;
   } ctrl_t;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_PAUSED = 1'b1
   } pause_state_e;

endpackage

// File: rtl/adam_timer_core.sv
// Prescaled up-counter with compare detection.
// Ports: clk_i/rst_i clock and async active-high reset; en_i counts when set;
// freeze_i holds prescaler and counter; auto_reload_i reloads 0 on match;
// presc_i/compare_i programmed values; presc_wr_i clears the prescaler;
// value_wr_i/value_wdata_i load the counter (wins over a tick);
// value_o current count; match_set_o pulses in a tick cycle whose count hits compare.
module adam_timer_core
   import adam_apb_timer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = TIMER_DATA_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  en_i,
   input  logic                  freeze_i,
   input  logic                  auto_reload_i,
   input  logic [DATA_WIDTH-1:0] presc_i,
   input  logic [DATA_WIDTH-1:0] compare_i,
   input  logic                  presc_wr_i,
   input  logic                  value_wr_i,
   input  logic [DATA_WIDTH-1:0] value_wdata_i,
   output logic [DATA_WIDTH-1:0] value_o,
   output logic                  match_set_o
);

   logic [DATA_WIDTH-1:0] pcnt_q, pcnt_d;
   logic [DATA_WIDTH-1:0] value_q, value_d;
   logic                  run, tick, hit;

   // Prescaler / counter next state
   always_comb begin
      run     = en_i & ~freeze_i;
      tick    = run & (pcnt_q == presc_i);
      hit     = (value_q == compare_i);
      pcnt_d  = pcnt_q;
      value_d = value_q;

      // Reprogramming either the divider or the count restarts the divider phase
      if (presc_wr_i || value_wr_i) begin
         pcnt_d = '0;
      end else if (run) begin
         pcnt_d = tick ? '0 : pcnt_q + DATA_WIDTH'(1);
      end

      if (value_wr_i) begin
         value_d = value_wdata_i;
      end else if (tick) begin
         value_d = (hit && auto_reload_i) ? '0 : value_q + DATA_WIDTH'(1);
      end

      match_set_o = tick & hit;
      value_o     = value_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pcnt_q  <= '0;
         value_q <= '0;
      end else begin
         pcnt_q  <= pcnt_d;
         value_q <= value_d;
      end
   end

endmodule

// File: rtl/adam_apb_timer.sv
// APB-slave timer: register decode, register file and pause handshake around
// adam_timer_core.
// Ports: clk_i/rst_i clock and async active-high reset; pause_req_i/pause_ack_o
// pause handshake; paddr_i..pstrb_i APB request (pprot_i, paddr_i[1:0] unused);
// pready_o/prdata_o/pslverr_o zero-wait APB response; irq_o level interrupt.
module adam_apb_timer
   import adam_apb_timer_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = TIMER_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = TIMER_DATA_WIDTH
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    pause_req_i,
   output logic                    pause_ack_o,
   input  logic [ADDR_WIDTH-1:0]   paddr_i,
   input  logic [2:0]              pprot_i,
   input  logic                    psel_i,
   input  logic                    penable_i,
   input  logic                    pwrite_i,
   input  logic [DATA_WIDTH-1:0]   pwdata_i,
   input  logic [DATA_WIDTH/8-1:0] pstrb_i,
   output logic                    pready_o,
   output logic [DATA_WIDTH-1:0]   prdata_o,
   output logic                    pslverr_o,
   output logic                    irq_o
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   pause_state_e          state_q, state_d;
   logic                  running, freeze;
   ctrl_t                 ctrl_q, ctrl_d;
   logic [DATA_WIDTH-1:0] presc_q, presc_d, compare_q, compare_d;
   logic                  match_q, match_d, match_set;
   logic [DATA_WIDTH-1:0] value, value_wdata, wmask;
   logic [2:0]            word_idx;
   logic                  mapped, access, wr_en;
   logic                  wr_ctrl, wr_presc, wr_value, wr_compare, wr_status;
   logic                  status_clr;
   logic                  unused_apb;

   assign unused_apb = ^{pprot_i, paddr_i[1:0]};

   // Byte-enable mask from pstrb
   for (genvar b = 0; b < STRB_WIDTH; b++) begin : g_wmask
      assign wmask[8*b +: 8] = {8{pstrb_i[b]}};
   end

   // Pause FSM: state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= ST_PAUSED;
      else       state_q <= state_d;
   end

   // Pause FSM: next state; never pause in the middle of a transfer
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:    if (pause_req_i && !psel_i) state_d = ST_PAUSED;
         ST_PAUSED: if (!pause_req_i)           state_d = ST_RUN;
         default:   state_d = ST_PAUSED;
      endcase
   end

   // Pause FSM: outputs
   always_comb begin
      pause_ack_o = 1'b0;
      running     = 1'b0;
      freeze      = 1'b1;
      case (state_q)
         ST_RUN: begin
            running = 1'b1;
            freeze  = 1'b0;
         end
         ST_PAUSED: pause_ack_o = 1'b1;
         default:   pause_ack_o = 1'b1;
      endcase
   end

   // Address decode and register-file next state
   always_comb begin
      word_idx   = paddr_i[4:2];
      mapped     = (paddr_i[ADDR_WIDTH-1:5] == '0) && (word_idx <= IDX_STATUS);
      access     = psel_i & penable_i & running;
      wr_en      = access & pwrite_i & mapped;
      wr_ctrl    = wr_en && (word_idx == IDX_CTRL);
      wr_presc   = wr_en && (word_idx == IDX_PRESC);
      wr_value   = wr_en && (word_idx == IDX_VALUE);
      wr_compare = wr_en && (word_idx == IDX_COMPARE);
      wr_status  = wr_en && (word_idx == IDX_STATUS);

      ctrl_d      = ctrl_q;
      presc_d     = presc_q;
      compare_d   = compare_q;
      value_wdata = (value & ~wmask) | (pwdata_i & wmask);

      if (wr_ctrl && pstrb_i[0]) ctrl_d = ctrl_t'(pwdata_i[2:0]);
      if (wr_presc)   presc_d   = (presc_q   & ~wmask) | (pwdata_i & wmask);
      if (wr_compare) compare_d = (compare_q & ~wmask) | (pwdata_i & wmask);

      // A new match outranks a simultaneous write-1-to-clear
      status_clr = wr_status & pstrb_i[0] & pwdata_i[STATUS_MATCH_BIT];
      match_d    = match_set | (match_q & ~status_clr);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ctrl_q    <= '0;
         presc_q   <= '0;
         compare_q <= '0;
         match_q   <= 1'b0;
      end else begin
         ctrl_q    <= ctrl_d;
         presc_q   <= presc_d;
         compare_q <= compare_d;
         match_q   <= match_d;
      end
   end

   // Zero-wait APB response, read data straight from the registers
   always_comb begin
      pready_o  = access;
      pslverr_o = access & ~mapped;
      prdata_o  = '0;
      if (psel_i && mapped) begin
         case (word_idx)
            IDX_CTRL:    prdata_o = DATA_WIDTH'({ctrl_q.irq_en, ctrl_q.auto_reload, ctrl_q.en});
            IDX_PRESC:   prdata_o = presc_q;
            IDX_VALUE:   prdata_o = value;
            IDX_COMPARE: prdata_o = compare_q;
            IDX_STATUS:  prdata_o = DATA_WIDTH'(match_q);
            default:     prdata_o = '0;
         endcase
      end
      irq_o = match_q & ctrl_q.irq_en;
   end

   adam_timer_core #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_core (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .en_i          (ctrl_q.en),
      .freeze_i      (freeze),
      .auto_reload_i (ctrl_q.auto_reload),
      .presc_i       (presc_q),
      .compare_i     (compare_q),
      .presc_wr_i    (wr_presc),
      .value_wr_i    (wr_value),
      .value_wdata_i (value_wdata),
      .value_o       (value),
      .match_set_o   (match_set)
   );

endmodule

// File: tb/tb_adam_apb_timer.sv
// Directed self-checking bench for adam_apb_timer.
module tb_adam_apb_timer;

   localparam logic [31:0] A_CTRL    = 32'h00;
   localparam logic [31:0] A_PRESC   = 32'h04;
   localparam logic [31:0] A_VALUE   = 32'h08;
   localparam logic [31:0] A_COMPARE = 32'h0C;
   localparam logic [31:0] A_STATUS  = 32'h10;

   logic        clk = 1'b0;
   logic        rst;
   logic        pause_req;
   logic        pause_ack;
   logic [31:0] paddr;
   logic [2:0]  pprot;
   logic        psel, penable, pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic        pready;
   logic [31:0] prdata;
   logic        pslverr;
   logic        irq;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   adam_apb_timer dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .pause_req_i (pause_req),
      .pause_ack_o (pause_ack),
      .paddr_i     (paddr),
      .pprot_i     (pprot),
      .psel_i      (psel),
      .penable_i   (penable),
      .pwrite_i    (pwrite),
      .pwdata_i    (pwdata),
      .pstrb_i     (pstrb),
      .pready_o    (pready),
      .prdata_o    (prdata),
      .pslverr_o   (pslverr),
      .irq_o       (irq)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One APB transfer; returns with the completing edge +1 time unit behind us
   task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, output logic [31:0] rdata, output logic err);
      int n;
      rdata = '0;
      err   = 1'b0;
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
      @(posedge clk); #1;
      penable = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (pready) begin
            rdata = prdata;
            err   = pslverr;
            break;
         end
         n++;
         if (n >= 50) begin
            check("pready_timeout", 32'(pready), 32'd1);
            break;
         end
      end
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_write_strb(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      logic [31:0] unused_rd;
      logic        unused_err;
      apb_xfer(1'b1, addr, data, strb, unused_rd, unused_err);
   endtask

   task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
      apb_write_strb(addr, data, 4'hF);
   endtask

   task automatic read_check(input string tag, input logic [31:0] addr,
                             input logic [31:0] exp, input logic exp_err);
      logic [31:0] d;
      logic        e;
      apb_xfer(1'b0, addr, 32'h0, 4'h0, d, e);
      check(tag, d, exp);
      check({tag, "_err"}, 32'(e), 32'(exp_err));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; pause_req = 1'b1;
      paddr = '0; pprot = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      pwdata = '0; pstrb = '0;

      // ---- reset state and pause release
      #12;
      check("rst_ack",     32'(pause_ack), 32'd1);
      check("rst_irq",     32'(irq),       32'd0);
      check("rst_pready",  32'(pready),    32'd0);
      check("rst_prdata",  prdata,         32'd0);
      check("rst_pslverr", 32'(pslverr),   32'd0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("ack_req_held", 32'(pause_ack), 32'd1);
      @(posedge clk); #1 pause_req = 1'b0;
      @(negedge clk);
      check("ack_before_drop", 32'(pause_ack), 32'd1);
      @(negedge clk);
      check("ack_dropped", 32'(pause_ack), 32'd0);

      read_check("rd_ctrl",    A_CTRL,    32'd0, 1'b0);
      read_check("rd_presc",   A_PRESC,   32'd0, 1'b0);
      read_check("rd_value",   A_VALUE,   32'd0, 1'b0);
      read_check("rd_compare", A_COMPARE, 32'd0, 1'b0);
      read_check("rd_status",  A_STATUS,  32'd0, 1'b0);
      read_check("rd_0x14",    32'h14,    32'd0, 1'b1);
      read_check("rd_0x1c",    32'h1C,    32'd0, 1'b1);

      // ---- PRESC=3, COMPARE=5, EN|IRQ_EN: one step per 4 cycles, match at 5
      apb_write(A_PRESC,   32'd3);
      apb_write(A_COMPARE, 32'd5);
      apb_write(A_CTRL,    32'b101);
      for (int m = 0; m < 28; m++) begin
         @(negedge clk);
         check($sformatf("presc_value_%0d", m), dut.u_core.value_q, 32'(m / 4));
         check($sformatf("presc_irq_%0d", m),   32'(irq), 32'(m >= 24));
      end
      read_check("presc_status", A_STATUS, 32'd1, 1'b0);
      apb_write(A_CTRL, 32'd0);
      apb_write(A_STATUS, 32'd1);
      read_check("status_w1c", A_STATUS, 32'd0, 1'b0);
      check("irq_after_w1c", 32'(irq), 32'd0);

      // ---- auto-reload, PRESC=0, COMPARE=2: 0,1,2,0,1,2,...
      apb_write(A_PRESC,   32'd0);
      apb_write(A_COMPARE, 32'd2);
      apb_write(A_VALUE,   32'd0);
      apb_write(A_CTRL,    32'b111);
      for (int m = 0; m < 8; m++) begin
         @(negedge clk);
         check($sformatf("ar_value_%0d", m), dut.u_core.value_q, 32'(m % 3));
         check($sformatf("ar_irq_%0d", m),   32'(irq), 32'(m >= 3));
      end
      apb_write(A_CTRL,   32'b110);
      apb_write(A_VALUE,  32'd3);
      apb_write(A_STATUS, 32'd1);
      check("ar_irq_cleared", 32'(irq), 32'd0);
      read_check("ar_status_cleared", A_STATUS, 32'd0, 1'b0);
      // VALUE reload then W1C lands exactly on the 2->0 match edge
      apb_write(A_CTRL,  32'b111);
      apb_write(A_VALUE, 32'd0);
      check("ar_value_written", dut.u_core.value_q, 32'd0);
      check("ar_irq_pre", 32'(irq), 32'd0);
      apb_write(A_STATUS, 32'd1);
      check("w1c_vs_set_irq", 32'(irq), 32'd1);
      read_check("w1c_vs_set_status", A_STATUS, 32'd1, 1'b0);
      apb_write(A_CTRL, 32'd0);

      // ---- silent wrap and byte strobes
      apb_write(A_STATUS,  32'd1);
      apb_write(A_VALUE,   32'hFFFF_FFFF);
      apb_write(A_COMPARE, 32'd7);
      apb_write(A_CTRL,    32'b101);
      @(negedge clk);
      check("wrap_pre", dut.u_core.value_q, 32'hFFFF_FFFF);
      @(negedge clk);
      check("wrap_zero", dut.u_core.value_q, 32'd0);
      check("wrap_irq",  32'(irq), 32'd0);
      @(negedge clk);
      check("wrap_one",  dut.u_core.value_q, 32'd1);
      apb_write(A_CTRL, 32'd0);
      apb_write_strb(A_COMPARE, 32'hAABB_CCDD, 4'b0010);
      read_check("strb_compare", A_COMPARE, 32'h0000_CC07, 1'b0);

      // ---- pause with a pending transfer, stalled read while paused
      apb_write(A_STATUS,  32'd1);
      apb_write(A_COMPARE, 32'h0000_FFFF);
      apb_write(A_VALUE,   32'd0);
      apb_write(A_CTRL,    32'b001);                  // edge E, value = cycles since E
      @(posedge clk); #1;                             // E+1
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = A_CTRL; pause_req = 1'b1;
      @(posedge clk); #1;                             // E+2
      penable = 1'b1;
      @(negedge clk);
      check("pause_ack_busy", 32'(pause_ack), 32'd0);
      check("pause_rd_ready", 32'(pready),    32'd1);
      check("pause_rd_data",  prdata,         32'd1);
      @(posedge clk); #1;                             // E+3
      psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      check("pause_ack_wait", 32'(pause_ack), 32'd0);
      @(negedge clk);                                 // after E+4
      check("pause_ack_up",   32'(pause_ack),     32'd1);
      check("pause_frozen_a", dut.u_core.value_q, 32'd4);
      repeat (5) @(negedge clk);
      check("pause_frozen_b", dut.u_core.value_q, 32'd4);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = A_VALUE;
      @(posedge clk); #1;
      penable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("pause_stall_%0d", i), 32'(pready), 32'd0);
      end
      @(posedge clk); #1 pause_req = 1'b0;
      @(negedge clk);
      check("resume_stall", 32'(pready), 32'd0);
      @(negedge clk);
      check("resume_ready", 32'(pready),    32'd1);
      check("resume_data",  prdata,         32'd4);
      check("resume_ack",   32'(pause_ack), 32'd0);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
      check("resume_count", dut.u_core.value_q, 32'd5);

      // ---- asynchronous reset mid-count and mid-write
      apb_write(A_CTRL,    32'd0);
      apb_write(A_VALUE,   32'd0);
      apb_write(A_COMPARE, 32'd2);
      apb_write(A_CTRL,    32'b111);
      repeat (5) @(negedge clk);
      check("pre_rst_irq", 32'(irq), 32'd1);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = A_PRESC; pwdata = 32'h55; pstrb = 4'hF;
      @(posedge clk); #1;
      penable = 1'b1;
      @(negedge clk);
      check("midwr_ready", 32'(pready), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("async_irq",    32'(irq),           32'd0);
      check("async_ack",    32'(pause_ack),     32'd1);
      check("async_pready", 32'(pready),        32'd0);
      check("async_value",  dut.u_core.value_q, 32'd0);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      check("post_rst_ack", 32'(pause_ack), 32'd1);
      read_check("post_rst_ctrl",    A_CTRL,    32'd0, 1'b0);
      read_check("post_rst_presc",   A_PRESC,   32'd0, 1'b0);
      read_check("post_rst_value",   A_VALUE,   32'd0, 1'b0);
      read_check("post_rst_compare", A_COMPARE, 32'd0, 1'b0);
      read_check("post_rst_status",  A_STATUS,  32'd0, 1'b0);
      check("post_rst_irq", 32'(irq), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
